// File: rtl/sad_pkg.sv
// Shared definitions for the SAD motion-search datapath: block geometry,
// default pixel width, width helpers and the controller state encoding.
package sad_pkg;

  localparam int unsigned BLK_DIM    = 16;
  localparam int unsigned BLK_PIX    = BLK_DIM * BLK_DIM;
  localparam int unsigned DWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A 16x16 sum of absolute differences needs 8 extra bits over one pixel.
  function automatic int unsigned sad_width(input int unsigned dw);
    return 8 + dw;
  endfunction

  // Signed width able to hold +/-srange.
  function automatic int unsigned mv_width(input int unsigned srange);
    return $clog2(srange + 1) + 1;
  endfunction

endpackage

// File: rtl/sad_search_ctrl_if.sv
// Bus between the motion-search controller and its surroundings: search
// command/result, reference fetch request/return and SAD engine operands.
interface sad_search_ctrl_if
  import sad_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned MVW    = 5,
  parameter int unsigned SADW   = sad_width(DWIDTH)
);
  localparam int unsigned BLKW = BLK_PIX * DWIDTH;

  logic                   start;
  logic [BLKW-1:0]        cur_blk;
  logic                   busy;
  logic                   ref_req;
  logic signed [MVW-1:0]  ref_mvx;
  logic signed [MVW-1:0]  ref_mvy;
  logic                   ref_gnt;
  logic                   ref_vld;
  logic [BLKW-1:0]        ref_blk;
  logic                   sad_cal_en;
  logic [BLKW-1:0]        sad_din;
  logic [BLKW-1:0]        sad_ref;
  logic [SADW-1:0]        sad_in;
  logic                   sad_in_vld;
  logic                   done;
  logic [SADW-1:0]        best_sad;
  logic signed [MVW-1:0]  best_mvx;
  logic signed [MVW-1:0]  best_mvy;

  modport master (
    input  start, cur_blk, ref_gnt, ref_vld, ref_blk, sad_in, sad_in_vld,
    output busy, ref_req, ref_mvx, ref_mvy, sad_cal_en, sad_din, sad_ref,
           done, best_sad, best_mvx, best_mvy
  );

  modport slave (
    output start, cur_blk, ref_gnt, ref_vld, ref_blk, sad_in, sad_in_vld,
    input  busy, ref_req, ref_mvx, ref_mvy, sad_cal_en, sad_din, sad_ref,
           done, best_sad, best_mvx, best_mvy
  );

endinterface

// File: rtl/sad_mv_scan.sv
// Raster-order motion-vector counter over [-SRANGE, +SRANGE]^2; holds at the
// last candidate so an extra advance cannot run past the window.
module sad_mv_scan #(
  parameter int unsigned SRANGE = 8,
  parameter int unsigned MVW    = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_init,
  input  logic                  i_adv,
  output logic signed [MVW-1:0] o_mvx,
  output logic signed [MVW-1:0] o_mvy,
  output logic                  o_last_c
);
  localparam logic signed [MVW-1:0] MV_MAX = MVW'(SRANGE);
  localparam logic signed [MVW-1:0] MV_MIN = -MV_MAX;

  logic signed [MVW-1:0] r_mvx;
  logic signed [MVW-1:0] r_mvy;
  logic                  w_row_end;

  assign w_row_end = (r_mvx == MV_MAX);
  assign o_last_c  = w_row_end && (r_mvy == MV_MAX);
  assign o_mvx     = r_mvx;
  assign o_mvy     = r_mvy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mvx <= '0;
      r_mvy <= '0;
    end else if (i_init) begin
      r_mvx <= MV_MIN;
      r_mvy <= MV_MIN;
    end else if (i_adv && !o_last_c) begin
      if (w_row_end) begin
        r_mvx <= MV_MIN;
        r_mvy <= r_mvy + MVW'(1);
      end else begin
        r_mvx <= r_mvx + MVW'(1);
      end
    end
  end

endmodule

// File: rtl/sad_search_ctrl.sv
// Full-search motion-estimation controller: issues every candidate MV to the
// fetch unit, forwards returned blocks to the SAD engine, tracks the minimum.
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned SRANGE = 8,
  parameter int unsigned MVW    = 5,
  parameter int unsigned SADW   = sad_width(DWIDTH)
) (
  input logic               clk,
  input logic               rstn,
  sad_search_ctrl_if.master bus
);
  localparam int unsigned BLKW = BLK_PIX * DWIDTH;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  w_start;
  logic                  w_grant;
  logic                  w_res;
  logic                  w_best_load;
  logic                  w_final;
  logic                  w_iss_last;
  logic                  w_res_last;
  logic signed [MVW-1:0] w_iss_mvx;
  logic signed [MVW-1:0] w_iss_mvy;
  logic signed [MVW-1:0] w_res_mvx;
  logic signed [MVW-1:0] w_res_mvy;

  logic                  r_busy;
  logic                  r_ref_req;
  logic                  r_done;
  logic                  r_have_best;
  logic                  r_sad_cal_en;
  logic [BLKW-1:0]       r_sad_din;
  logic [BLKW-1:0]       r_sad_ref;
  logic [SADW-1:0]       r_best_sad;
  logic signed [MVW-1:0] r_best_mvx;
  logic signed [MVW-1:0] r_best_mvy;

  assign w_start = bus.start && (r_state == ST_IDLE);
  assign w_grant = r_ref_req && bus.ref_gnt;
  assign w_res   = bus.sad_in_vld && (r_state != ST_IDLE);

  sad_mv_scan #(.SRANGE(SRANGE), .MVW(MVW)) u_issue_scan (
    .clk      (clk),
    .rstn     (rstn),
    .i_init   (w_start),
    .i_adv    (w_grant),
    .o_mvx    (w_iss_mvx),
    .o_mvy    (w_iss_mvy),
    .o_last_c (w_iss_last)
  );

  sad_mv_scan #(.SRANGE(SRANGE), .MVW(MVW)) u_result_scan (
    .clk      (clk),
    .rstn     (rstn),
    .i_init   (w_start),
    .i_adv    (w_res),
    .o_mvx    (w_res_mvx),
    .o_mvy    (w_res_mvy),
    .o_last_c (w_res_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (w_final)                    w_state_nxt = ST_IDLE;
        else if (w_grant && w_iss_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (w_final) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Strict less-than keeps the earlier raster candidate on ties.
  always_comb begin
    w_best_load = 1'b0;
    w_final     = 1'b0;
    if (w_res) begin
      w_best_load = !r_have_best || (bus.sad_in < r_best_sad);
      w_final     = w_res_last;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy    <= 1'b0;
      r_ref_req <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_ref_req <= (w_state_nxt == ST_ISSUE);
      r_done    <= w_final;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_have_best <= 1'b0;
      r_best_sad  <= '1;
      r_best_mvx  <= '0;
      r_best_mvy  <= '0;
    end else if (w_start) begin
      r_have_best <= 1'b0;
    end else if (w_res) begin
      r_have_best <= 1'b1;
      if (w_best_load) begin
        r_best_sad <= bus.sad_in;
        r_best_mvx <= w_res_mvx;
        r_best_mvy <= w_res_mvy;
      end
    end
  end

  // Engine feed: reference blocks pass straight through regardless of state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sad_cal_en <= 1'b0;
      r_sad_din    <= '0;
      r_sad_ref    <= '0;
    end else begin
      r_sad_cal_en <= bus.ref_vld;
      if (w_start)     r_sad_din <= bus.cur_blk;
      if (bus.ref_vld) r_sad_ref <= bus.ref_blk;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.ref_req    = r_ref_req;
  assign bus.ref_mvx    = w_iss_mvx;
  assign bus.ref_mvy    = w_iss_mvy;
  assign bus.sad_cal_en = r_sad_cal_en;
  assign bus.sad_din    = r_sad_din;
  assign bus.sad_ref    = r_sad_ref;
  assign bus.done       = r_done;
  assign bus.best_sad   = r_best_sad;
  assign bus.best_mvx   = r_best_mvx;
  assign bus.best_mvy   = r_best_mvy;

endmodule
